// File: rtl/sdp_sram_pkg.sv
// Shared types and helpers for the sdp_sram_be storage macro.
package sdp_sram_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } clr_state_e;

   localparam int unsigned RDW_OLD        = 0;
   localparam int unsigned RDW_NEW        = 1;
   localparam int unsigned MAX_LANE_WIDTH = 64;

   // Even parity bit for one lane; callers zero-extend the lane to MAX_LANE_WIDTH.
   function automatic logic lane_parity(input logic [MAX_LANE_WIDTH-1:0] lane);
      return ^lane;
   endfunction

endpackage

// File: rtl/sdp_sram_clr_ctrl.sv
// Clear sequencer: walks every address once, ascending, while holding busy high.
module sdp_sram_clr_ctrl
   import sdp_sram_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr,
   output logic                  busy,
   output logic                  clr_we,
   output logic [ADDR_WIDTH-1:0] clr_addr
);

   localparam int unsigned CNT_WIDTH = ADDR_WIDTH + 1;
   // One extra bit so the count can reach DEPTH without wrapping to zero.
   localparam logic [CNT_WIDTH-1:0] DEPTH_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};

   clr_state_e           state;
   clr_state_e           state_next;
   logic [CNT_WIDTH-1:0] cnt;
   logic [CNT_WIDTH-1:0] cnt_next;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         cnt   <= '0;
         busy  <= 1'b0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
         busy  <= (state_next == ST_CLEAR);
      end
   end

   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      case (state)
         ST_IDLE: begin
            if (clr) begin
               state_next = ST_CLEAR;
               cnt_next   = '0;
            end
         end
         ST_CLEAR: begin
            cnt_next = cnt + CNT_WIDTH'(1);
            if (cnt_next == DEPTH_CNT) begin
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   assign clr_we   = busy;
   assign clr_addr = cnt[ADDR_WIDTH-1:0];

endmodule

// File: rtl/sdp_sram_be.sv
// Simple-dual-port SRAM with byte enables, 1/2-cycle read latency and a clear sequencer.
// Optional per-lane even parity is built when SDP_SRAM_PARITY_EN is defined.
module sdp_sram_be
   import sdp_sram_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned BYTE_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 4,
   parameter int unsigned RD_LATENCY = 1,
   parameter int unsigned RDW_MODE   = 0
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             clr,
   output logic                             busy,
   input  logic                             wr_en,
   input  logic [ADDR_WIDTH-1:0]            wr_addr,
   input  logic [DATA_WIDTH-1:0]            wr_data,
   input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wr_be,
   input  logic                             rd_en,
   input  logic [ADDR_WIDTH-1:0]            rd_addr,
   output logic [DATA_WIDTH-1:0]            rd_data,
   output logic                             rd_valid
`ifdef SDP_SRAM_PARITY_EN
   ,
   input  logic                             par_inject,
   output logic                             par_err
`endif
);

   localparam int unsigned NUM_LANES  = DATA_WIDTH / BYTE_WIDTH;
   localparam int unsigned DEPTH      = 1 << ADDR_WIDTH;
   localparam logic        RDW_NEW_EN = (RDW_MODE == RDW_NEW);

   if ((RD_LATENCY != 1) && (RD_LATENCY != 2)) begin : g_bad_latency
      $error("sdp_sram_be: RD_LATENCY must be 1 or 2");
   end
   if ((DATA_WIDTH % BYTE_WIDTH) != 0) begin : g_bad_width
      $error("sdp_sram_be: DATA_WIDTH must be a multiple of BYTE_WIDTH");
   end

   logic                  clr_we;
   logic [ADDR_WIDTH-1:0] clr_addr;
   logic                  wr_acc_c;
   logic                  rd_acc_c;
   logic                  rdw_hit_c;
   logic [DATA_WIDTH-1:0] merged_c;
   logic [DATA_WIDTH-1:0] rd_word_c;
   logic [DATA_WIDTH-1:0] mem [DEPTH];

   sdp_sram_clr_ctrl #(
      .ADDR_WIDTH(ADDR_WIDTH)
   ) u_clr_ctrl (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (clr),
      .busy    (busy),
      .clr_we  (clr_we),
      .clr_addr(clr_addr)
   );

   assign wr_acc_c  = wr_en & ~busy;
   assign rd_acc_c  = rd_en & ~busy;
   assign rdw_hit_c = RDW_NEW_EN & wr_acc_c & (wr_addr == rd_addr);

   // Byte merge: new lanes where enabled, current contents elsewhere.
   always_comb begin
      merged_c = mem[wr_addr];
      for (int unsigned i = 0; i < NUM_LANES; i++) begin
         if (wr_be[i]) begin
            merged_c[i*BYTE_WIDTH +: BYTE_WIDTH] = wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
         end
      end
   end

   assign rd_word_c = rdw_hit_c ? merged_c : mem[rd_addr];

   // Storage has no reset; clear and user writes never coincide since busy blocks the latter.
   always_ff @(posedge clk) begin
      if (clr_we) begin
         mem[clr_addr] <= '0;
      end else if (wr_acc_c) begin
         mem[wr_addr] <= merged_c;
      end
   end

   logic                  v1;
   logic [DATA_WIDTH-1:0] d1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1 <= 1'b0;
         d1 <= '0;
      end else begin
         v1 <= rd_acc_c;
         if (rd_acc_c) begin
            d1 <= rd_word_c;
         end
      end
   end

`ifdef SDP_SRAM_PARITY_EN
   logic [NUM_LANES-1:0] par_mem [DEPTH];
   logic [NUM_LANES-1:0] merged_par_c;
   logic [NUM_LANES-1:0] rd_par_c;
   logic [NUM_LANES-1:0] rd_calc_c;
   logic                 rd_err_c;
   logic                 e1;

   always_comb begin
      merged_par_c = par_mem[wr_addr];
      for (int unsigned i = 0; i < NUM_LANES; i++) begin
         if (wr_be[i]) begin
            merged_par_c[i] = lane_parity(MAX_LANE_WIDTH'(wr_data[i*BYTE_WIDTH +: BYTE_WIDTH]))
                              ^ par_inject;
         end
      end
   end

   assign rd_par_c = rdw_hit_c ? merged_par_c : par_mem[rd_addr];

   always_comb begin
      rd_calc_c = '0;
      for (int unsigned i = 0; i < NUM_LANES; i++) begin
         rd_calc_c[i] = lane_parity(MAX_LANE_WIDTH'(rd_word_c[i*BYTE_WIDTH +: BYTE_WIDTH]));
      end
   end

   assign rd_err_c = |(rd_calc_c ^ rd_par_c);

   always_ff @(posedge clk) begin
      if (clr_we) begin
         par_mem[clr_addr] <= '0;
      end else if (wr_acc_c) begin
         par_mem[wr_addr] <= merged_par_c;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e1 <= 1'b0;
      end else begin
         e1 <= rd_acc_c & rd_err_c;
      end
   end
`endif

   // Output stage: direct for latency 1, one more register for latency 2.
   if (RD_LATENCY == 1) begin : g_lat1
      assign rd_valid = v1;
      assign rd_data  = d1;
`ifdef SDP_SRAM_PARITY_EN
      assign par_err  = e1;
`endif
   end else begin : g_lat2
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
         end else begin
            rd_valid <= v1;
            if (v1) begin
               rd_data <= d1;
            end
         end
      end
`ifdef SDP_SRAM_PARITY_EN
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            par_err <= 1'b0;
         end else begin
            par_err <= e1;
         end
      end
`endif
   end

endmodule

// File: tb/tb_sdp_sram_be.sv
// Directed bench for sdp_sram_be: dut_a is latency 1 / old-data, dut_b is latency 2 / new-data.
module tb_sdp_sram_be;
   import sdp_sram_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        clr;
   logic        wr_en;
   logic [3:0]  wr_addr;
   logic [31:0] wr_data;
   logic [3:0]  wr_be;
   logic        rd_en;
   logic [3:0]  rd_addr;
   logic        busy_a, busy_b;
   logic        rd_valid_a, rd_valid_b;
   logic [31:0] rd_data_a, rd_data_b;
`ifdef SDP_SRAM_PARITY_EN
   logic        par_inject;
   logic        par_err_a, par_err_b;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sdp_sram_be #(
      .DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(4), .RD_LATENCY(1), .RDW_MODE(RDW_OLD)
   ) dut_a (
      .clk(clk), .rst_n(rst_n), .clr(clr), .busy(busy_a),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_valid(rd_valid_a)
`ifdef SDP_SRAM_PARITY_EN
      , .par_inject(par_inject), .par_err(par_err_a)
`endif
   );

   sdp_sram_be #(
      .DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(4), .RD_LATENCY(2), .RDW_MODE(RDW_NEW)
   ) dut_b (
      .clk(clk), .rst_n(rst_n), .clr(clr), .busy(busy_b),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_valid(rd_valid_b)
`ifdef SDP_SRAM_PARITY_EN
      , .par_inject(par_inject), .par_err(par_err_b)
`endif
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      clr = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
      rd_en = 1'b0; rd_addr = '0;
`ifdef SDP_SRAM_PARITY_EN
      par_inject = 1'b0;
`endif
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
      wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
      cyc();
      wr_en = 1'b0; wr_be = '0;
   endtask

   // Single read; captures dut_a one cycle later and dut_b two cycles later.
   task automatic rd(input logic [3:0] a, output logic [31:0] da, output logic va,
                     output logic [31:0] db, output logic vb);
      rd_en = 1'b1; rd_addr = a;
      cyc();
      rd_en = 1'b0;
      da = rd_data_a; va = rd_valid_a;
      cyc();
      db = rd_data_b; vb = rd_valid_b;
   endtask

   task automatic fill(input logic [31:0] d);
      for (int i = 0; i < 16; i++) wr(4'(i), d, 4'hF);
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n = 1'b0;
      #12;
      checks++; if (rd_data_a !== 32'h0) begin errors++; $display("FAIL reset_rd_data_a got %h want 0", rd_data_a); end
      checks++; if (rd_data_b !== 32'h0) begin errors++; $display("FAIL reset_rd_data_b got %h want 0", rd_data_b); end
      checks++; if ({rd_valid_a, rd_valid_b} !== 2'b00) begin errors++; $display("FAIL reset_rd_valid got %b want 00", {rd_valid_a, rd_valid_b}); end
      checks++; if ({busy_a, busy_b} !== 2'b00) begin errors++; $display("FAIL reset_busy got %b want 00", {busy_a, busy_b}); end
`ifdef SDP_SRAM_PARITY_EN
      checks++; if ({par_err_a, par_err_b} !== 2'b00) begin errors++; $display("FAIL reset_par_err got %b want 00", {par_err_a, par_err_b}); end
`endif
      @(negedge clk);
      rst_n = 1'b1;
      cyc();
   endtask

   task automatic test_basic();
      wr(4'd3, 32'hDEADBEEF, 4'hF);
      rd_en = 1'b1; rd_addr = 4'd3;
      cyc();
      rd_en = 1'b0;
      checks++; if (rd_valid_a !== 1'b1) begin errors++; $display("FAIL basic_valid_a got %b want 1", rd_valid_a); end
      checks++; if (rd_data_a !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_data_a got %h want deadbeef", rd_data_a); end
      checks++; if (rd_valid_b !== 1'b0) begin errors++; $display("FAIL basic_early_valid_b got %b want 0", rd_valid_b); end
      cyc();
      checks++; if (rd_valid_a !== 1'b0) begin errors++; $display("FAIL basic_valid_a_drop got %b want 0", rd_valid_a); end
      checks++; if (rd_data_a !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_hold_a got %h want deadbeef", rd_data_a); end
      checks++; if (rd_valid_b !== 1'b1) begin errors++; $display("FAIL basic_valid_b got %b want 1", rd_valid_b); end
      checks++; if (rd_data_b !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_data_b got %h want deadbeef", rd_data_b); end
   endtask

   task automatic test_byte_en();
      logic [31:0] da, db;
      logic        va, vb;
      wr(4'd5, 32'h11223344, 4'hF);
      wr(4'd5, 32'hAABBCCDD, 4'b0101);
      wr(4'd5, 32'h99999999, 4'b0000);
      rd(4'd5, da, va, db, vb);
      checks++; if (da !== 32'h11BB33DD || va !== 1'b1) begin errors++; $display("FAIL byte_en_a got %h/%b want 11bb33dd/1", da, va); end
      checks++; if (db !== 32'h11BB33DD || vb !== 1'b1) begin errors++; $display("FAIL byte_en_b got %h/%b want 11bb33dd/1", db, vb); end
   endtask

   task automatic test_rdw();
      logic [31:0] da, db;
      logic        va, vb;
      wr(4'd7, 32'h0, 4'hF);
      wr_en = 1'b1; wr_addr = 4'd7; wr_data = 32'h12345678; wr_be = 4'hF;
      rd_en = 1'b1; rd_addr = 4'd7;
      cyc();
      wr_en = 1'b0; rd_en = 1'b0;
      checks++; if (rd_data_a !== 32'h0 || rd_valid_a !== 1'b1) begin errors++; $display("FAIL rdw_old_a got %h/%b want 00000000/1", rd_data_a, rd_valid_a); end
      cyc();
      checks++; if (rd_data_b !== 32'h12345678 || rd_valid_b !== 1'b1) begin errors++; $display("FAIL rdw_new_b got %h/%b want 12345678/1", rd_data_b, rd_valid_b); end
      rd(4'd7, da, va, db, vb);
      checks++; if (da !== 32'h12345678 || va !== 1'b1) begin errors++; $display("FAIL rdw_after_a got %h/%b want 12345678/1", da, va); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] vals [4];
      for (int i = 0; i < 4; i++) begin
         vals[i] = 32'hC0DE0000 + 32'(i * 17);
         wr(4'(i), vals[i], 4'hF);
      end
      for (int k = 0; k < 6; k++) begin
         rd_en = (k < 4); rd_addr = 4'(k);
         cyc();
         checks++;
         if (rd_valid_a !== (k < 4) || ((k < 4) && rd_data_a !== vals[k])) begin
            errors++; $display("FAIL stream_a k=%0d got %h/%b", k, rd_data_a, rd_valid_a);
         end
         checks++;
         if (rd_valid_b !== (k >= 1 && k < 5) || ((k >= 1 && k < 5) && rd_data_b !== vals[k-1])) begin
            errors++; $display("FAIL stream_b k=%0d got %h/%b", k, rd_data_b, rd_valid_b);
         end
      end
      rd_en = 1'b0;
   endtask

   task automatic test_clear();
      int n;
      logic [31:0] da, db;
      logic        va, vb;
      fill(32'hFFFFFFFF);
      clr = 1'b1; rd_en = 1'b1; rd_addr = 4'd0;
      cyc();
      clr = 1'b0; rd_en = 1'b0;
      checks++; if (busy_a !== 1'b1 || busy_b !== 1'b1) begin errors++; $display("FAIL clr_busy_rise got %b%b want 11", busy_a, busy_b); end
      checks++; if (rd_valid_a !== 1'b1 || rd_data_a !== 32'hFFFFFFFF) begin errors++; $display("FAIL clr_same_cycle_read got %h/%b want ffffffff/1", rd_data_a, rd_valid_a); end
      n = 0;
      while (busy_a === 1'b1 && n < 40) begin
         clr = 1'b1; wr_en = 1'b1; wr_addr = 4'd2; wr_data = 32'h12345678; wr_be = 4'hF;
         rd_en = 1'b1; rd_addr = 4'(n);
         cyc();
         n++;
         checks++;
         if (rd_valid_a !== 1'b0 || rd_valid_b !== (n == 1) || busy_b !== busy_a) begin
            errors++; $display("FAIL clr_busy_cycle n=%0d valid=%b%b busy=%b%b", n, rd_valid_a, rd_valid_b, busy_a, busy_b);
         end
      end
      idle_inputs();
      checks++; if (n != 16) begin errors++; $display("FAIL clr_busy_len got %0d want 16", n); end
      for (int i = 0; i < 16; i++) begin
         rd(4'(i), da, va, db, vb);
         checks++;
         if (da !== 32'h0 || va !== 1'b1 || db !== 32'h0 || vb !== 1'b1) begin
            errors++; $display("FAIL clr_zero addr=%0d got %h/%b %h/%b want 0/1", i, da, va, db, vb);
         end
      end
   endtask

   task automatic test_reset_mid_clear();
      logic [31:0] da, db, exp;
      logic        va, vb;
      fill(32'hFFFFFFFF);
      rd(4'd15, da, va, db, vb);
      clr = 1'b1;
      cyc();
      clr = 1'b0;
      repeat (8) cyc();
      rst_n = 1'b0;
      #1;
      checks++; if ({busy_a, busy_b} !== 2'b00) begin errors++; $display("FAIL midclr_busy got %b want 00", {busy_a, busy_b}); end
      checks++; if ({rd_valid_a, rd_valid_b} !== 2'b00) begin errors++; $display("FAIL midclr_valid got %b want 00", {rd_valid_a, rd_valid_b}); end
      checks++; if (rd_data_a !== 32'h0 || rd_data_b !== 32'h0) begin errors++; $display("FAIL midclr_data got %h %h want 0", rd_data_a, rd_data_b); end
      @(negedge clk);
      rst_n = 1'b1;
      cyc();
      checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL midclr_no_resume got %b want 0", busy_a); end
      for (int i = 0; i < 16; i++) begin
         exp = (i < 8) ? 32'h0 : 32'hFFFFFFFF;
         rd(4'(i), da, va, db, vb);
         checks++;
         if (da !== exp || va !== 1'b1 || db !== exp || vb !== 1'b1) begin
            errors++; $display("FAIL midclr_mem addr=%0d got %h %h want %h", i, da, db, exp);
         end
      end
   endtask

`ifdef SDP_SRAM_PARITY_EN
   task automatic test_parity();
      par_inject = 1'b1;
      wr(4'd9, 32'h0F0F0F0F, 4'hF);
      par_inject = 1'b0;
      rd_en = 1'b1; rd_addr = 4'd9;
      cyc();
      rd_en = 1'b0;
      checks++; if (par_err_a !== 1'b1 || rd_valid_a !== 1'b1) begin errors++; $display("FAIL par_inject_a got err=%b valid=%b want 1/1", par_err_a, rd_valid_a); end
      cyc();
      checks++; if (par_err_b !== 1'b1 || rd_valid_b !== 1'b1) begin errors++; $display("FAIL par_inject_b got err=%b valid=%b want 1/1", par_err_b, rd_valid_b); end
      checks++; if (par_err_a !== 1'b0) begin errors++; $display("FAIL par_pulse_a got %b want 0", par_err_a); end
      wr(4'd9, 32'h0F0F0F0F, 4'hF);
      rd_en = 1'b1; rd_addr = 4'd9;
      cyc();
      rd_en = 1'b0;
      checks++; if (par_err_a !== 1'b0 || rd_valid_a !== 1'b1) begin errors++; $display("FAIL par_clean_a got err=%b valid=%b want 0/1", par_err_a, rd_valid_a); end
      cyc();
      checks++; if (par_err_b !== 1'b0 || rd_valid_b !== 1'b1) begin errors++; $display("FAIL par_clean_b got err=%b valid=%b want 0/1", par_err_b, rd_valid_b); end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_byte_en();
      test_rdw();
      test_back_to_back();
      test_clear();
      test_reset_mid_clear();
`ifdef SDP_SRAM_PARITY_EN
      test_parity();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog timeout after %0d checks", checks);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/sdp_sram_be.md
Name: sdp_sram_be

Overview:
Parametrised simple-dual-port SRAM with one write port and one read port, both synchronous.
- Write port has per-byte write enables.
- Read latency is configurable (1 or 2 cycles) and reads carry a valid strobe.
- Read-during-write behaviour is selectable by parameter.
- A built-in clear sequencer zeroes the array on request.
- Used as the generic storage macro behind FIFOs, register files and packet buffers.

Parameters:
- DATA_WIDTH, 32: word width in bits; must be a multiple of BYTE_WIDTH.
- BYTE_WIDTH, 8: bits per write-enable lane.
- ADDR_WIDTH, 4: address width; DEPTH = 2**ADDR_WIDTH words.
- RD_LATENCY, 1: read latency, 1 or 2 cycles; any other value is a elaboration error.
- RDW_MODE, 0: same-address read-during-write result; 0 = old data, 1 = new (merged) data.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  pulse; starts the array clear sequence.
- busy  out  1  high while clear is in progress.
- wr_en  in  1  write request.
- wr_addr  in  ADDR_WIDTH  write address.
- wr_data  in  DATA_WIDTH  write data.
- wr_be  in  DATA_WIDTH/BYTE_WIDTH  byte-lane enables; bit i covers data bits [i*BYTE_WIDTH +: BYTE_WIDTH].
- rd_en  in  1  read request.
- rd_addr  in  ADDR_WIDTH  read address.
- rd_data  out  DATA_WIDTH  read data, registered.
- rd_valid  out  1  one-cycle strobe per accepted read.

Behaviour:
- Reset (async assert, sync-safe release):
  - rd_data = 0, rd_valid = 0, busy = 0.
  - Clear FSM = IDLE; read pipeline flushed.
  - Array contents are NOT reset.
- Write: at a rising edge with wr_en=1 and busy=0, each lane i with wr_be[i]=1 is updated; lanes with wr_be[i]=0 keep their content. wr_be=0 is a no-op.
- Read acceptance: a read is accepted at an edge with rd_en=1 and busy=0.
  - RD_LATENCY=1: rd_data and rd_valid update at the same edge (data visible in the next cycle).
  - RD_LATENCY=2: one extra output register stage.
  - One accepted read per cycle; back-to-back reads give back-to-back rd_valid.
- rd_data holds its last value when no read completes; rd_valid is 0 in those cycles.
- Same-address read and write in the same cycle:
  - RDW_MODE=0: rd_data returns pre-write contents.
  - RDW_MODE=1: rd_data returns the merged word: wr_data on enabled lanes, old content on the rest.
  - Different addresses are fully independent.
- Clear FSM, states IDLE and CLEAR:
  - IDLE -> CLEAR on clr=1; busy asserts in the following cycle.
  - CLEAR writes all-zero to one address per cycle, ascending from 0 to DEPTH-1 (DEPTH cycles total).
  - After writing DEPTH-1 it returns to IDLE; busy deasserts the next cycle.
  - The clear address counter is ADDR_WIDTH+1 bits so the terminal count does not wrap.
- While busy=1:
  - wr_en and rd_en are ignored (dropped, not queued); clr is ignored.
  - Reads accepted before busy rose still complete normally.
- clr with wr_en/rd_en in the same IDLE cycle: that write/read is still accepted; clear starts next cycle.
- Reset during CLEAR: FSM returns to IDLE and busy=0. The array is left partially cleared; no resume.
- Address wrap: none; every address in [0, DEPTH-1] is valid and no out-of-range case exists.

Optional Feature:
- Macro: SDP_SRAM_PARITY_EN.
- When defined:
  - One even-parity bit is stored per byte lane, written with its lane and zeroed by clear.
  - On each read, parity is checked and output par_err (1 bit) pulses aligned with rd_valid if any lane mismatches.
  - par_err resets to 0.
  - Input par_inject (1 bit) inverts the stored parity bits of the word being written, for test.
- When undefined: no parity storage, and neither par_err nor par_inject exists.

Decomposition:
- Package sdp_sram_pkg:
  - clear-FSM state enum (ST_IDLE, ST_CLEAR);
  - RDW_OLD=0 and RDW_NEW=1 constants;
  - function computing per-lane even parity.
- Sub-module sdp_sram_clr_ctrl: clear FSM plus address counter; outputs busy, clear write enable and clear address.
- Array, byte merge and read pipeline stay in the top module.

Test Plan:
- Basic readback (RD_LATENCY=1): write 0xDEADBEEF to addr 3 with wr_be=4'hF, then read addr 3 -> rd_valid high 1 cycle later, rd_data=0xDEADBEEF.
- Byte enables: addr 5 holds 0x11223344; write 0xAABBCCDD with wr_be=4'b0101 -> read returns 0x11BB33DD.
- Read-during-write: addr 7 holds 0x0; same-cycle write 0x12345678 (be=F) and read addr 7 -> RDW_MODE=0 gives 0x00000000; RDW_MODE=1 gives 0x12345678.
- Latency 2, streaming: RD_LATENCY=2, reads of addrs 0..3 on consecutive cycles -> rd_valid high on 4 consecutive cycles starting 2 cycles after the first request, with data in order.
- Clear sequence: fill all 16 words with 0xFFFFFFFF, pulse clr -> busy high for exactly 16 cycles; rd_en/wr_en during busy give no rd_valid and no write; afterwards every address reads 0.
- Reset and parity: assert rst_n=0 at clear cycle 8 -> busy=0, rd_valid=0, rd_data=0 immediately; addrs 0..7 read 0, addrs 8..15 keep old data. With SDP_SRAM_PARITY_EN: write with par_inject=1, then read -> par_err=1 aligned with rd_valid; a normal write then read -> par_err=0.
